emp_arbiter: RTL and testbench

EMP_ARBITER -- requirements
Module: emp_arbiter

---
 rtl/emp_arbiter.sv | 107 ++++++++++
 tb/tb_emp_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/emp_arbiter.sv
// Round-robin arbiter that captures one employee record, holds it for HOLD_CYC cycles,
// then presents it downstream until it is accepted.
module emp_arbiter #(
    parameter int N_REQ    = 3,
    parameter int HOLD_CYC = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ-1:0][47:0]         req_rec,
    output logic [N_REQ-1:0]               req_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [47:0]                    out_rec,
    output logic [$clog2(N_REQ)-1:0]       out_src,
    output logic [4:0]                     state
);

    localparam int SRC_W = $clog2(N_REQ);
    localparam int CNT_W = 4;

    typedef enum logic [4:0] {
        IDLE  = 5'd2,
        COUNT = 5'd7,
        LAST  = 5'd11
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   holdCnt_q;
    logic [SRC_W-1:0]   lastGrant_q;
    logic [SRC_W-1:0]   outSrc_q;
    logic [47:0]        outRec_q;
    logic               outValid_q;

    logic               grantHit_d;
    logic [SRC_W-1:0]   grantIdx_d;

    // Search upward from the requester after the last one served, wrapping at N_REQ.
    always_comb begin
        int cand;
        cand       = 0;
        grantHit_d = 1'b0;
        grantIdx_d = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(lastGrant_q) + 1 + k) % N_REQ;
            if (!grantHit_d && req_valid[cand]) begin
                grantHit_d = 1'b1;
                grantIdx_d = SRC_W'(cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grantHit_d) begin
            req_ready[grantIdx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            outValid_q  <= 1'b0;
            outRec_q    <= '0;
            outSrc_q    <= '0;
            holdCnt_q   <= '0;
            lastGrant_q <= SRC_W'(N_REQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (grantHit_d) begin
                        outRec_q  <= req_rec[grantIdx_d];
                        outSrc_q  <= grantIdx_d;
                        holdCnt_q <= CNT_W'(HOLD_CYC - 1);
                        state_q   <= COUNT;
                    end
                end
                COUNT: begin
                    if (holdCnt_q == '0) begin
                        state_q    <= LAST;
                        outValid_q <= 1'b1;
                    end else begin
                        holdCnt_q <= holdCnt_q - 1'b1;
                    end
                end
                LAST: begin
                    // Leaving LAST never grants; the next grant waits for a true IDLE cycle.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        outValid_q  <= 1'b0;
                        lastGrant_q <= outSrc_q;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = outValid_q;
    assign out_rec   = outRec_q;
    assign out_src   = outSrc_q;
    assign state     = state_q;

endmodule

// File: tb/tb_emp_arbiter.sv
// Directed bench for emp_arbiter: a default build (N_REQ=3, HOLD_CYC=4) and a HOLD_CYC=1 build.
module tb_emp_arbiter;

    logic             clk;
    logic             rst_n;
    logic [2:0]       reqValid;
    logic [2:0][47:0] reqRec;
    logic [2:0]       reqReady;
    logic             outValid;
    logic             outReady;
    logic [47:0]      outRec;
    logic [1:0]       outSrc;
    logic [4:0]       state;

    logic [2:0]       reqValid1;
    logic [2:0][47:0] reqRec1;
    logic [2:0]       reqReady1;
    logic             outValid1;
    logic             outReady1;
    logic [47:0]      outRec1;
    logic [1:0]       outSrc1;
    logic [4:0]       state1;

    int nChecks = 0;
    int nFails  = 0;

    emp_arbiter #(.N_REQ(3), .HOLD_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid), .req_rec(reqRec), .req_ready(reqReady),
        .out_valid(outValid), .out_ready(outReady), .out_rec(outRec),
        .out_src(outSrc), .state(state)
    );

    emp_arbiter #(.N_REQ(3), .HOLD_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid1), .req_rec(reqRec1), .req_ready(reqReady1),
        .out_valid(outValid1), .out_ready(outReady1), .out_rec(outRec1),
        .out_src(outSrc1), .state(state1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n     = 1'b0;
        reqValid  = '0;
        outReady  = 1'b0;
        reqValid1 = '0;
        outReady1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        reqValid  = '0;
        reqRec    = '0;
        outReady  = 1'b0;
        reqValid1 = '0;
        reqRec1   = '0;
        outReady1 = 1'b0;
        #2;
        rst_n = 1'b0;
        #2;
        nChecks++; if (state !== 5'd2) begin nFails++; $display("[TB] FAIL reset_state: got %0d want 2", state); end
        nChecks++; if (outValid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b want 0", outValid); end
        nChecks++; if (outRec !== 48'h0) begin nFails++; $display("[TB] FAIL reset_rec: got %h want 0", outRec); end
        nChecks++; if (outSrc !== 2'd0) begin nFails++; $display("[TB] FAIL reset_src: got %0d want 0", outSrc); end
        nChecks++; if (reqReady !== 3'b000) begin nFails++; $display("[TB] FAIL reset_ready: got %b want 000", reqReady); end
        nChecks++; if (state1 !== 5'd2) begin nFails++; $display("[TB] FAIL reset_state1: got %0d want 2", state1); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        reqRec[0] = {32'd33, 16'd9548};
        reqValid  = 3'b001;
        #1;
        nChecks++; if (reqReady !== 3'b001) begin nFails++; $display("[TB] FAIL basic_ready: got %b want 001", reqReady); end
        nChecks++; if (state !== 5'd2) begin nFails++; $display("[TB] FAIL basic_idle: got %0d want 2", state); end
        tick();
        reqValid = '0;
        for (int i = 0; i < 4; i++) begin
            nChecks++; if (state !== 5'd7) begin nFails++; $display("[TB] FAIL basic_count%0d: got %0d want 7", i, state); end
            nChecks++; if (outValid !== 1'b0) begin nFails++; $display("[TB] FAIL basic_early_valid%0d: got %b want 0", i, outValid); end
            tick();
        end
        nChecks++; if (state !== 5'd11) begin nFails++; $display("[TB] FAIL basic_last: got %0d want 11", state); end
        nChecks++; if (outValid !== 1'b1) begin nFails++; $display("[TB] FAIL basic_valid: got %b want 1", outValid); end
        nChecks++; if (outRec !== 48'h0000_0021_254C) begin nFails++; $display("[TB] FAIL basic_rec: got %h want 0000_0021_254c", outRec); end
        nChecks++; if (outSrc !== 2'd0) begin nFails++; $display("[TB] FAIL basic_src: got %0d want 0", outSrc); end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        nChecks++; if (state !== 5'd2) begin nFails++; $display("[TB] FAIL basic_return: got %0d want 2", state); end
        nChecks++; if (outValid !== 1'b0) begin nFails++; $display("[TB] FAIL basic_valid_drop: got %b want 0", outValid); end
    endtask

    task automatic test_round_robin();
        logic [47:0] expRec;
        int          exp;
        doReset();
        for (int i = 0; i < 3; i++) reqRec[i] = {32'(1000 + i), 16'(16'hA0 + i)};
        reqValid = 3'b111;
        outReady = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp    = g % 3;
            expRec = {32'(1000 + exp), 16'(16'hA0 + exp)};
            #1;
            nChecks++; if (reqReady !== 3'(1 << exp)) begin nFails++; $display("[TB] FAIL rr_ready%0d: got %b want %b", g, reqReady, 3'(1 << exp)); end
            tick();
            nChecks++; if (reqReady !== 3'b000) begin nFails++; $display("[TB] FAIL rr_count_ready%0d: got %b want 000", g, reqReady); end
            repeat (4) tick();
            nChecks++; if (outValid !== 1'b1) begin nFails++; $display("[TB] FAIL rr_valid%0d: got %b want 1", g, outValid); end
            nChecks++; if (outSrc !== 2'(exp)) begin nFails++; $display("[TB] FAIL rr_src%0d: got %0d want %0d", g, outSrc, exp); end
            nChecks++; if (outRec !== expRec) begin nFails++; $display("[TB] FAIL rr_rec%0d: got %h want %h", g, outRec, expRec); end
            tick();
        end
        reqValid = '0;
        outReady = 1'b0;
    endtask

    task automatic test_stall();
        doReset();
        reqRec[1] = {32'd77, 16'h1234};
        reqValid  = 3'b010;
        #1;
        nChecks++; if (reqReady !== 3'b010) begin nFails++; $display("[TB] FAIL stall_ready: got %b want 010", reqReady); end
        tick();
        reqValid = 3'b011;
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            nChecks++; if (state !== 5'd11) begin nFails++; $display("[TB] FAIL stall_state%0d: got %0d want 11", i, state); end
            nChecks++; if (outValid !== 1'b1) begin nFails++; $display("[TB] FAIL stall_valid%0d: got %b want 1", i, outValid); end
            nChecks++; if (outRec !== {32'd77, 16'h1234}) begin nFails++; $display("[TB] FAIL stall_rec%0d: got %h want 0000004d1234", i, outRec); end
            nChecks++; if (outSrc !== 2'd1) begin nFails++; $display("[TB] FAIL stall_src%0d: got %0d want 1", i, outSrc); end
            nChecks++; if (reqReady !== 3'b000) begin nFails++; $display("[TB] FAIL stall_ready%0d: got %b want 000", i, reqReady); end
            tick();
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        nChecks++; if (state !== 5'd2) begin nFails++; $display("[TB] FAIL stall_return: got %0d want 2", state); end
        nChecks++; if (reqReady !== 3'b001) begin nFails++; $display("[TB] FAIL stall_next_grant: got %b want 001", reqReady); end
        reqValid = '0;
    endtask

    task automatic test_reset_mid_count();
        doReset();
        reqRec[2] = {32'd55, 16'd66};
        reqValid  = 3'b100;
        #1;
        nChecks++; if (reqReady !== 3'b100) begin nFails++; $display("[TB] FAIL midrst_ready: got %b want 100", reqReady); end
        tick();
        reqValid = '0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        nChecks++; if (state !== 5'd2) begin nFails++; $display("[TB] FAIL midrst_state: got %0d want 2", state); end
        nChecks++; if (outValid !== 1'b0) begin nFails++; $display("[TB] FAIL midrst_valid: got %b want 0", outValid); end
        nChecks++; if (outRec !== 48'h0) begin nFails++; $display("[TB] FAIL midrst_rec: got %h want 0", outRec); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            nChecks++; if (outValid !== 1'b0 || state !== 5'd2) begin nFails++; $display("[TB] FAIL midrst_quiet%0d: got valid=%b state=%0d want valid=0 state=2", i, outValid, state); end
        end
        reqValid = 3'b111;
        #1;
        nChecks++; if (reqReady !== 3'b001) begin nFails++; $display("[TB] FAIL midrst_first_grant: got %b want 001", reqReady); end
        reqValid = '0;
    endtask

    task automatic test_hold_one();
        doReset();
        reqRec1[0] = {32'd5, 16'd6};
        reqValid1  = 3'b001;
        #1;
        nChecks++; if (reqReady1 !== 3'b001) begin nFails++; $display("[TB] FAIL hold1_ready: got %b want 001", reqReady1); end
        tick();
        reqValid1 = '0;
        nChecks++; if (state1 !== 5'd7 || outValid1 !== 1'b0) begin nFails++; $display("[TB] FAIL hold1_count: got state=%0d valid=%b want state=7 valid=0", state1, outValid1); end
        tick();
        nChecks++; if (state1 !== 5'd11 || outValid1 !== 1'b1) begin nFails++; $display("[TB] FAIL hold1_last: got state=%0d valid=%b want state=11 valid=1", state1, outValid1); end
        nChecks++; if (outRec1 !== {32'd5, 16'd6}) begin nFails++; $display("[TB] FAIL hold1_rec: got %h want 000000050006", outRec1); end
        outReady1 = 1'b1;
        tick();
        outReady1 = 1'b0;
        nChecks++; if (state1 !== 5'd2) begin nFails++; $display("[TB] FAIL hold1_return: got %0d want 2", state1); end
    endtask

    task automatic test_negative_age();
        doReset();
        reqRec[1] = 48'hFFFF_FFFF_FFFF;
        reqValid  = 3'b010;
        tick();
        reqValid = '0;
        repeat (4) tick();
        nChecks++; if (outRec !== 48'hFFFF_FFFF_FFFF) begin nFails++; $display("[TB] FAIL neg_rec: got %h want ffffffffffff", outRec); end
        nChecks++; if (outSrc !== 2'd1) begin nFails++; $display("[TB] FAIL neg_src: got %0d want 1", outSrc); end
    endtask

    task automatic test_lose_place();
        doReset();
        reqRec[1] = {32'd11, 16'd1};
        reqRec[2] = {32'd22, 16'd2};
        reqValid  = 3'b111;
        outReady  = 1'b1;
        tick();
        reqValid = 3'b100;
        repeat (5) tick();
        #1;
        nChecks++; if (reqReady !== 3'b100) begin nFails++; $display("[TB] FAIL lose_ready: got %b want 100", reqReady); end
        tick();
        reqValid = '0;
        repeat (4) tick();
        nChecks++; if (outSrc !== 2'd2 || outRec !== {32'd22, 16'd2}) begin nFails++; $display("[TB] FAIL lose_capture: got src=%0d rec=%h want src=2 rec=000000160002", outSrc, outRec); end
        outReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_stall();
        test_reset_mid_count();
        test_hold_one();
        test_negative_age();
        test_lose_place();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
